// File: rtl/lc_splitter_elastic_fifo.sv
// Elastic FIFO behind the loopback splitter timing adapter: drops and counts words that arrive while full.
// The optional XGMII idle fill on an empty FIFO is enabled by defining LC_SPLITTER_IDLE_FILL_EN.
module lc_splitter_elastic_fifo #(
  parameter int DATA_WIDTH     = 72,
  parameter int DEPTH          = 16,
  parameter int ADDR_WIDTH     = 4,
  parameter int ALMOST_FULL_TH = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   fill_level,
  output logic                  almost_full,
  output logic [15:0]           overflow_cnt,
  input  logic                  overflow_clr
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, fill_nxt;
  logic                  full, wr_en, drop, take, rd_en, head_avail, load;
  logic                  head_idle;

`ifdef LC_SPLITTER_IDLE_FILL_EN
  localparam logic [DATA_WIDTH-1:0] IDLE_WORD = DATA_WIDTH'({8'hFF, 64'h0707070707070707});
`else
  assign head_idle = 1'b0;
`endif

  assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                 (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign wr_en = in_valid & ~full;
  assign drop  = in_valid & full;
  assign take  = out_valid & out_ready;
  // The head word stays in memory until accepted, so fill_level never exceeds DEPTH.
  assign rd_en = take & ~head_idle;

  assign wr_ptr_nxt = wr_ptr + {{ADDR_WIDTH{1'b0}}, wr_en};
  assign rd_ptr_nxt = rd_ptr + {{ADDR_WIDTH{1'b0}}, rd_en};
  assign fill_nxt   = wr_ptr_nxt - rd_ptr_nxt;
  // Words written on this edge are not yet visible, hence the pre-edge wr_ptr.
  assign head_avail = (rd_ptr_nxt != wr_ptr);
  assign load       = ~out_valid | take;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[ADDR_WIDTH-1:0]] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fill_level  <= '0;
      almost_full <= 1'b0;
      in_ready    <= 1'b1;
    end else begin
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      fill_level  <= fill_nxt;
      almost_full <= (fill_nxt >= (ADDR_WIDTH+1)'(ALMOST_FULL_TH));
      in_ready    <= (fill_nxt != (ADDR_WIDTH+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow_cnt <= '0;
    end else if (overflow_clr) begin
      overflow_cnt <= {15'd0, drop};
    end else if (drop && overflow_cnt != 16'hFFFF) begin
      overflow_cnt <= overflow_cnt + 16'd1;
    end
  end

`ifdef LC_SPLITTER_IDLE_FILL_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b1;
      out_data  <= IDLE_WORD;
      head_idle <= 1'b1;
    end else if (load) begin
      out_valid <= 1'b1;
      if (head_avail) begin
        out_data  <= mem[rd_ptr_nxt[ADDR_WIDTH-1:0]];
        head_idle <= 1'b0;
      end else begin
        out_data  <= IDLE_WORD;
        head_idle <= 1'b1;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= head_avail;
      if (head_avail) out_data <= mem[rd_ptr_nxt[ADDR_WIDTH-1:0]];
    end
  end
`endif

endmodule

// File: tb/tb_lc_splitter_elastic_fifo.sv
// Self-checking bench for lc_splitter_elastic_fifo (default build): directed test-plan cases plus
// random traffic, checked each cycle against a queue-based reference model.
module tb_lc_splitter_elastic_fifo;
  localparam int DW = 72, DEPTH = 16, AW = 4, AF = 12;

  logic          clk = 1'b0, reset_n = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0, out_ready = 1'b0, overflow_clr = 1'b0;
  logic          in_ready, out_valid, almost_full;
  logic [DW-1:0] out_data;
  logic [AW:0]   fill_level;
  logic [15:0]   overflow_cnt;

  lc_splitter_elastic_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .ALMOST_FULL_TH(AF)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .fill_level(fill_level),
    .almost_full(almost_full), .overflow_cnt(overflow_cnt), .overflow_clr(overflow_clr));

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;

  // Reference model: words held (head first), whether the head is presented, and the drop count.
  logic [DW-1:0] mq[$];
  bit            shown = 1'b0;
  int            ocnt = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit was_full, took, dropped;
    if (!reset_n) begin
      mq.delete();
      shown = 1'b0;
      ocnt  = 0;
    end else begin
      was_full = (mq.size() == DEPTH);
      took     = shown && out_ready;
      dropped  = in_valid && was_full;
      if (took) void'(mq.pop_front());
      if (!shown || took) shown = (mq.size() > 0);
      if (in_valid && !was_full) mq.push_back(in_data);
      if (overflow_clr) ocnt = dropped ? 1 : 0;
      else if (dropped && ocnt < 65535) ocnt++;
    end
  endtask

  task automatic compare();
    chk("out_valid", DW'(out_valid), DW'(shown));
    if (shown) chk("out_data", out_data, mq[0]);
    chk("fill_level", DW'(fill_level), DW'(mq.size()));
    chk("almost_full", DW'(almost_full), DW'(mq.size() >= AF));
    chk("in_ready", DW'(in_ready), DW'(mq.size() < DEPTH));
    chk("overflow_cnt", DW'(overflow_cnt), DW'(ocnt));
  endtask

  task automatic step(input bit cmp);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (cmp) compare();
  endtask

  function automatic logic [DW-1:0] rnd_word();
    return {8'($urandom()), $urandom(), $urandom()};
  endfunction

  initial begin
    // Reset state
    reset_n = 1'b0;
    step(1'b1);
    step(1'b1);
    chk("rst_out_data", out_data, '0);
    chk("rst_in_ready", DW'(in_ready), DW'(1'b1));
    reset_n = 1'b1;

    // Single word, 2-cycle latency
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 72'h01_DEADBEEF_CAFEF00D;
    step(1'b1);
    in_valid = 1'b0;
    chk("single_lat1", DW'(out_valid), DW'(1'b0));
    step(1'b1);
    chk("single_lat2", DW'(out_valid), DW'(1'b1));
    chk("single_data", out_data, 72'h01_DEADBEEF_CAFEF00D);
    step(1'b1);
    chk("single_fill0", DW'(fill_level), '0);

    // Burst of 17 into a stalled sink
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i + 72'h100);
      step(1'b1);
      if (i == 11) chk("af_at_12", DW'(almost_full), DW'(1'b1));
      if (i == 10) chk("af_at_11", DW'(almost_full), DW'(1'b0));
    end
    chk("burst_ovf", DW'(overflow_cnt), DW'(16'd1));
    chk("burst_in_ready", DW'(in_ready), DW'(1'b0));
    chk("burst_fill", DW'(fill_level), DW'(16));

    // Full with simultaneous read and write: write is dropped
    out_ready = 1'b1;
    in_data   = 72'hAA_5555AAAA_5555AAAA;
    chk("full_head", out_data, DW'(72'h100));
    step(1'b1);
    chk("full_rw_fill", DW'(fill_level), DW'(15));
    chk("full_rw_ovf", DW'(overflow_cnt), DW'(16'd2));
    chk("full_rw_next", out_data, DW'(72'h101));
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) step(1'b1);

    overflow_clr = 1'b1;
    step(1'b1);
    overflow_clr = 1'b0;
    chk("clr_only", DW'(overflow_cnt), '0);

    // Continuous streaming, 100 words
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i + 72'h1000);
      step(1'b1);
      chk("stream_fill_le2", DW'(fill_level <= 2), DW'(1'b1));
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1);
    chk("stream_ovf", DW'(overflow_cnt), '0);

    // Reset with 8 words stored
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = rnd_word();
      step(1'b1);
    end
    in_valid = 1'b0;
    reset_n  = 1'b0;
    step(1'b1);
    chk("midrst_valid", DW'(out_valid), DW'(1'b0));
    chk("midrst_fill", DW'(fill_level), '0);
    reset_n = 1'b1;
    out_ready = 1'b1;
    step(1'b1);
    step(1'b1);
    chk("midrst_no_emit", DW'(out_valid), DW'(1'b0));

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid     = ($urandom_range(0, 99) < 70);
      in_data      = rnd_word();
      out_ready    = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 45 : 85));
      overflow_clr = ($urandom_range(0, 99) < 2);
      step(1'b1);
    end
    overflow_clr = 1'b0;

    // Saturation of the overflow counter
    overflow_clr = 1'b1;
    in_valid = 1'b0;
    step(1'b1);
    overflow_clr = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 65540 + DEPTH; i++) begin
      in_data = DW'(i);
      step(1'b0);
    end
    compare();
    chk("sat_ovf", DW'(overflow_cnt), DW'(16'hFFFF));
    overflow_clr = 1'b1;
    step(1'b1);
    chk("clr_with_drop", DW'(overflow_cnt), DW'(16'd1));
    overflow_clr = 1'b0;
    in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
